// File: rtl/prog_loader.sv
// prog_loader: boot-time instruction-memory loader.
//
// Receives a framed byte stream and writes it into instruction memory while
// holding the processor in reset. Frame layout:
//   count[15:8], count[7:0], count x (4 bytes, big-endian word), checksum
// where checksum is the XOR of every count and data byte in the frame.
// The processor is released (CpuHold=0) only after a frame whose checksum
// matches.
//
// Handshake: a byte moves on a rising edge where ByteValid=1 and ByteReady=1.
// ByteReady is high in every receiving state and depends only on the state,
// never on ByteValid, so the loader never stalls mid-frame.
//
// Ports:
//   clk          system clock, rising edge
//   Reset        asynchronous active-low reset
//   Start        one-cycle pulse that begins a frame (IDLE/DONE/ERROR only)
//   ByteIn       stream byte
//   ByteValid    ByteIn is valid this cycle
//   ByteReady    loader accepts a byte this cycle
//   WrEn         one-cycle instruction-memory write strobe
//   WrAddr       byte address of the write (holds between writes)
//   WrData       word to write (holds between writes)
//   CpuHold      high keeps the processor in reset
//   Done         frame loaded with a good checksum
//   Error        frame rejected (oversize count, bad checksum, timeout)
//   WordsLoaded  words written in the current frame
//   StateDbg     current FSM state encoding, for observation only
module prog_loader #(
  parameter logic [31:0] ADDR_BASE      = 32'h0000_0000,
  parameter int unsigned MAX_WORDS      = 256,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [7:0]  ByteIn,
  input  logic        ByteValid,
  output logic        ByteReady,
  output logic        WrEn,
  output logic [31:0] WrAddr,
  output logic [31:0] WrData,
  output logic        CpuHold,
  output logic        Done,
  output logic        Error,
  output logic [15:0] WordsLoaded,
  output logic [2:0]  StateDbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CNT_HI = 3'd1,
    S_CNT_LO = 3'd2,
    S_DATA   = 3'd3,
    S_CSUM   = 3'd4,
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [7:0]  csum_q, csum_d;
  logic [23:0] word_q, word_d;        // first three bytes of the current word
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [15:0] words_q, words_d;
  logic        wr_en_q, wr_en_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic [31:0] timer_q, timer_d;

  logic        active;
  logic        xfer;
  logic        restart;
  logic        word_last;
  logic        timed_out;
  logic [15:0] count_full;
  logic [31:0] timer_next;

  assign active     = (state_q == S_CNT_HI) || (state_q == S_CNT_LO) ||
                      (state_q == S_DATA)   || (state_q == S_CSUM);
  assign xfer       = active && ByteValid;
  assign restart    = Start && ((state_q == S_IDLE) || (state_q == S_DONE) ||
                                (state_q == S_ERROR));
  assign word_last  = xfer && (state_q == S_DATA) && (byte_cnt_q == 2'd3);
  // Full count as it will be once the low byte lands this cycle.
  assign count_full = {count_q[15:8], ByteIn};
  assign timer_next = timer_q + 32'd1;
  assign timed_out  = (TIMEOUT_CYCLES != 0) && active && !xfer &&
                      (timer_next == TIMEOUT_CYCLES);

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (Start) state_d = S_CNT_HI;
      end
      S_CNT_HI: begin
        if (xfer) state_d = S_CNT_LO;
      end
      S_CNT_LO: begin
        if (xfer) begin
          if (32'(count_full) > MAX_WORDS) state_d = S_ERROR;
          else if (count_full == 16'd0)    state_d = S_CSUM;
          else                             state_d = S_DATA;
        end
      end
      S_DATA: begin
        // Leave on the last byte of the final word; its write strobe then
        // lands in the first CSUM cycle, where the checksum byte may already
        // be accepted.
        if (word_last && ((words_q + 16'd1) == count_q)) state_d = S_CSUM;
      end
      S_CSUM: begin
        if (xfer) state_d = (ByteIn == csum_q) ? S_DONE : S_ERROR;
      end
      default: state_d = S_IDLE;
    endcase
    if (timed_out) state_d = S_ERROR;
  end

  // Datapath next-state logic.
  always_comb begin
    count_d    = count_q;
    csum_d     = csum_q;
    word_d     = word_q;
    byte_cnt_d = byte_cnt_q;
    words_d    = words_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    timer_d    = timer_q;

    if (restart) begin
      count_d    = 16'd0;
      csum_d     = 8'd0;
      byte_cnt_d = 2'd0;
      words_d    = 16'd0;
      wr_addr_d  = ADDR_BASE;
      timer_d    = 32'd0;
    end else if (xfer) begin
      timer_d = 32'd0;
      if (state_q != S_CSUM) csum_d = csum_q ^ ByteIn;
      case (state_q)
        S_CNT_HI: count_d[15:8] = ByteIn;
        S_CNT_LO: count_d[7:0]  = ByteIn;
        S_DATA: begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          word_d     = {word_q[15:0], ByteIn};
          if (byte_cnt_q == 2'd3) begin
            wr_en_d   = 1'b1;
            wr_data_d = {word_q, ByteIn};
            // Address from the pre-increment word index; wraps modulo 2^32.
            wr_addr_d = ADDR_BASE + {14'd0, words_q, 2'b00};
            words_d   = words_q + 16'd1;
          end
        end
        default: ;
      endcase
    end else if (active) begin
      timer_d = timer_next;
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= S_IDLE;
      count_q    <= 16'd0;
      csum_q     <= 8'd0;
      word_q     <= 24'd0;
      byte_cnt_q <= 2'd0;
      words_q    <= 16'd0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= ADDR_BASE;
      wr_data_q  <= 32'd0;
      timer_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      csum_q     <= csum_d;
      word_q     <= word_d;
      byte_cnt_q <= byte_cnt_d;
      words_q    <= words_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      timer_q    <= timer_d;
    end
  end

  assign ByteReady   = active;
  assign WrEn        = wr_en_q;
  assign WrAddr      = wr_addr_q;
  assign WrData      = wr_data_q;
  assign Done        = (state_q == S_DONE);
  assign Error       = (state_q == S_ERROR);
  assign CpuHold     = (state_q != S_DONE);
  assign WordsLoaded = words_q;
  assign StateDbg    = state_q;

endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader: directed frames driven byte by byte, a
// frame-level model that predicts every output each cycle, and a write
// scoreboard holding the expected (address, data) pairs.
module tb_prog_loader;

  localparam logic [31:0] ADDR_BASE = 32'h0000_0000;
  localparam int MAX_WORDS = 256;
  localparam int TIMEOUT   = 16;

  typedef enum int {PH_IDLE, PH_BUSY, PH_DONE, PH_ERR} phase_e;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        Reset, Start, ByteValid;
  logic [7:0]  ByteIn;
  logic        ByteReady, WrEn, CpuHold, Done, Error;
  logic [31:0] WrAddr, WrData;
  logic [15:0] WordsLoaded;
  logic [2:0]  StateDbg;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  prog_loader #(
    .ADDR_BASE(ADDR_BASE),
    .MAX_WORDS(MAX_WORDS),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk),
    .Reset(Reset),
    .Start(Start),
    .ByteIn(ByteIn),
    .ByteValid(ByteValid),
    .ByteReady(ByteReady),
    .WrEn(WrEn),
    .WrAddr(WrAddr),
    .WrData(WrData),
    .CpuHold(CpuHold),
    .Done(Done),
    .Error(Error),
    .WordsLoaded(WordsLoaded),
    .StateDbg(StateDbg)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- frame-level model ----------------
  logic [63:0] exp_q[$];   // {addr, data} of writes still to be seen
  phase_e      m_phase   = PH_IDLE;
  int          m_nbytes  = 0;
  int          m_count   = 0;
  int          m_last    = 0;
  logic [7:0]  m_xor     = 8'h00;
  logic [31:0] m_acc     = 32'h0;
  logic [31:0] m_addr    = ADDR_BASE;
  logic [31:0] m_data    = 32'h0;
  logic [15:0] m_words   = 16'h0;
  bit          m_wr_pending = 1'b0;
  logic [31:0] lw_addr   = 32'hFFFF_FFFF;

  task automatic model_reset();
    m_phase = PH_IDLE;
    m_words = 16'h0;
    m_addr  = ADDR_BASE;
    m_data  = 32'h0;
    m_wr_pending = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_start();
    if (m_phase != PH_BUSY) begin
      m_phase  = PH_BUSY;
      m_nbytes = 0;
      m_count  = 0;
      m_xor    = 8'h00;
      m_words  = 16'h0;
      m_addr   = ADDR_BASE;
      m_last   = cyc;
    end
  endtask

  // Position of the byte within the frame decides its meaning.
  task automatic model_byte(input logic [7:0] b);
    if (m_phase != PH_BUSY) return;
    m_last = cyc;
    if (m_nbytes == 0) begin
      m_count = int'(b) * 256;
      m_xor   = m_xor ^ b;
    end else if (m_nbytes == 1) begin
      m_count = m_count + int'(b);
      m_xor   = m_xor ^ b;
      if (m_count > MAX_WORDS) m_phase = PH_ERR;
    end else if (m_nbytes < 2 + 4 * m_count) begin
      m_xor = m_xor ^ b;
      m_acc = {m_acc[23:0], b};
      if ((m_nbytes - 2) % 4 == 3) begin
        m_addr = ADDR_BASE + 32'(4 * int'(m_words));
        m_data = m_acc;
        exp_q.push_back({m_addr, m_data});
        m_words = m_words + 16'd1;
        m_wr_pending = 1'b1;
      end
    end else begin
      m_phase = (b == m_xor) ? PH_DONE : PH_ERR;
    end
    m_nbytes++;
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_phase == PH_BUSY && (cyc - m_last) >= TIMEOUT) m_phase = PH_ERR;
    chk("byte_ready", 32'(ByteReady), 32'(m_phase == PH_BUSY));
    chk("done",       32'(Done),      32'(m_phase == PH_DONE));
    chk("error",      32'(Error),     32'(m_phase == PH_ERR));
    chk("cpu_hold",   32'(CpuHold),   32'(m_phase != PH_DONE));
    chk("wr_en",      32'(WrEn),      32'(m_wr_pending));
    if (WrEn && m_wr_pending && exp_q.size() > 0) begin
      logic [63:0] e;
      e = exp_q.pop_front();
      chk("wr_addr_sb", WrAddr, e[63:32]);
      chk("wr_data_sb", WrData, e[31:0]);
      lw_addr = WrAddr;
    end
    m_wr_pending = 1'b0;
    chk("wr_addr",      WrAddr,             m_addr);
    chk("wr_data",      WrData,             m_data);
    chk("words_loaded", 32'(WordsLoaded),   32'(m_words));
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start();
    Start = 1'b1;
    @(posedge clk);
    #1;
    Start = 1'b0;
    model_start();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    ByteIn    = b;
    ByteValid = 1'b1;
    @(negedge clk);
    while (!ByteReady && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("ready_wait", 32'(ByteReady), 32'd1);
    @(posedge clk);
    #1;
    ByteValid = 1'b0;
    model_byte(b);
  endtask

  logic [7:0] good_frame [0:9];
  int t0;

  // ---------------- stimulus ----------------
  initial begin
    good_frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78,
                   8'h9A, 8'hBC, 8'hDE, 8'hF0};
    Reset = 1'b0; Start = 1'b0; ByteValid = 1'b0; ByteIn = 8'h00;
    #3;
    chk("rst_cpu_hold", 32'(CpuHold), 32'd1);
    chk("rst_done",     32'(Done),    32'd0);
    chk("rst_error",    32'(Error),   32'd0);
    chk("rst_ready",    32'(ByteReady), 32'd0);
    chk("rst_wr_en",    32'(WrEn),    32'd0);
    chk("rst_wr_addr",  WrAddr,       32'h0);
    chk("rst_wr_data",  WrData,       32'h0);
    chk("rst_words",    32'(WordsLoaded), 32'd0);
    idle(2);
    Reset = 1'b1;
    idle(2);

    // Good two-word frame; XOR of the ten frame bytes is 0x02.
    do_start();
    for (int i = 0; i < 10; i++) send_byte(good_frame[i]);
    chk("model_xor_good", 32'(m_xor), 32'h02);
    send_byte(8'h02);
    idle(2);
    chk("good_done",   32'(Done),    32'd1);
    chk("good_hold",   32'(CpuHold), 32'd0);
    chk("good_words",  32'(WordsLoaded), 32'd2);
    chk("good_lastwr", lw_addr,      32'h4);

    // Same frame, bad checksum: writes still happen, then error.
    do_start();
    for (int i = 0; i < 10; i++) send_byte(good_frame[i]);
    send_byte(8'h09);
    idle(2);
    chk("bad_error", 32'(Error),   32'd1);
    chk("bad_done",  32'(Done),    32'd0);
    chk("bad_hold",  32'(CpuHold), 32'd1);
    chk("bad_words", 32'(WordsLoaded), 32'd2);

    // Zero-word frame.
    do_start();
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    idle(2);
    chk("zero_done",  32'(Done), 32'd1);
    chk("zero_words", 32'(WordsLoaded), 32'd0);

    // Oversize count 257: error right after the second byte.
    do_start();
    send_byte(8'h01);
    send_byte(8'h01);
    @(negedge clk);
    chk("over_error", 32'(Error), 32'd1);
    chk("over_ready", 32'(ByteReady), 32'd0);
    idle(2);

    // Good frame with ByteValid toggling every cycle.
    do_start();
    for (int i = 0; i < 10; i++) begin
      send_byte(good_frame[i]);
      idle(1);
    end
    send_byte(8'h02);
    idle(2);
    chk("bp_done",  32'(Done), 32'd1);
    chk("bp_words", 32'(WordsLoaded), 32'd2);

    // Inter-byte timeout after the third data byte.
    do_start();
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    t0 = cyc;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (Error) break;
    end
    chk("timeout_cycles", 32'(cyc - t0), 32'd16);
    @(negedge clk);
    chk("timeout_ready", 32'(ByteReady), 32'd0);
    chk("timeout_words", 32'(WordsLoaded), 32'd0);
    idle(1);

    // Asynchronous reset between data bytes.
    do_start();
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'h22);
    @(posedge clk);
    #2;
    Reset = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(ByteReady), 32'd0);
    chk("mid_rst_hold",  32'(CpuHold),   32'd1);
    chk("mid_rst_error", 32'(Error),     32'd0);
    chk("mid_rst_words", 32'(WordsLoaded), 32'd0);
    chk("mid_rst_addr",  WrAddr,         32'h0);
    chk("mid_rst_data",  WrData,         32'h0);
    model_reset();
    idle(2);
    Reset = 1'b1;
    idle(1);

    // Good frame, then restart with a one-word frame (XOR is 0x23).
    do_start();
    for (int i = 0; i < 10; i++) send_byte(good_frame[i]);
    send_byte(8'h02);
    idle(1);
    do_start();
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'hDE);
    send_byte(8'hAD);
    send_byte(8'hBE);
    send_byte(8'hEF);
    chk("model_xor_one", 32'(m_xor), 32'h23);
    send_byte(8'h23);
    idle(2);
    chk("re_lastwr", lw_addr, 32'h0);
    chk("re_words",  32'(WordsLoaded), 32'd1);
    chk("re_done",   32'(Done), 32'd1);
    chk("re_data",   WrData, 32'hDEADBEEF);

    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
